// File: rtl/mips_mem_pkg.sv
// Shared definitions for the mips32 data-memory path: load/store opcodes,
// access sizes and the opcode decoder used by the memory responder.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    size_e size;
    logic  sign_ext;
    logic  legal;
  } op_decode_t;

  function automatic op_decode_t decode_op(input logic [5:0] op);
    op_decode_t d;
    d.is_load  = 1'b0;
    d.is_store = 1'b0;
    d.size     = SZ_WORD;
    d.sign_ext = 1'b0;
    d.legal    = 1'b1;
    case (op)
      OP_LB:  begin d.is_load  = 1'b1; d.size = SZ_BYTE; d.sign_ext = 1'b1; end
      OP_LH:  begin d.is_load  = 1'b1; d.size = SZ_HALF; d.sign_ext = 1'b1; end
      OP_LW:  begin d.is_load  = 1'b1; d.size = SZ_WORD; end
      OP_LBU: begin d.is_load  = 1'b1; d.size = SZ_BYTE; end
      OP_LHU: begin d.is_load  = 1'b1; d.size = SZ_HALF; end
      OP_SB:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
      OP_SW:  begin d.is_store = 1'b1; d.size = SZ_WORD; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] byte_off);
    logic m;
    case (size)
      SZ_HALF: m = byte_off[0];
      SZ_WORD: m = (byte_off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: builds the merged store word and byte enables,
// and extracts/extends the addressed lane of a read word for loads.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  byte_off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] load_data
);

  logic        [31:0] wrep;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_x;
  logic signed [31:0] half_x;

  // Lane 0 (lowest address) sits in the most significant byte.
  always_comb begin
    case (byte_off)
      2'd0:    byte_s = rword[31:24];
      2'd1:    byte_s = rword[23:16];
      2'd2:    byte_s = rword[15:8];
      default: byte_s = rword[7:0];
    endcase
    half_s = byte_off[1] ? rword[15:0] : rword[31:16];
    byte_x = byte_s;
    half_x = half_s;
  end

  always_comb begin
    byte_en   = 4'b1111;
    wrep      = wdata;
    load_data = rword;
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b1000 >> byte_off;
        wrep    = {4{wdata[7:0]}};
        if (sign_ext) load_data = byte_x;
        else          load_data = {24'b0, byte_s};
      end
      SZ_HALF: begin
        byte_en = byte_off[1] ? 4'b0011 : 4'b1100;
        wrep    = {2{wdata[15:0]}};
        if (sign_ext) load_data = half_x;
        else          load_data = {16'b0, half_s};
      end
      default: begin
        byte_en   = 4'b1111;
        wrep      = wdata;
        load_data = rword;
      end
    endcase
  end

  always_comb begin
    wword = rword;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) wword[8*i +: 8] = wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory for the mips32 memory stage: one load/store at a
// time over valid/ready, answered by a single-cycle response pulse.
module data_memory_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [5:0]           op_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          mem [DEPTH_WORDS];

  op_decode_t           dec;
  logic                 accept;
  logic                 enter_resp;
  logic                 out_of_range;
  logic                 err;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rword;
  logic [31:0]          wword;
  logic [31:0]          load_data;
  logic [3:0]           byte_en;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_q == WAIT) && (cnt_q == '0);

  // A LATENCY of 1 loads a zero count, so every access passes through WAIT
  // once and always works from the latched request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= CNT_W'(LATENCY - 1);
      else if ((state_q == WAIT) && (cnt_q != '0))
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      op_q    <= req_opcode;
      addr_q  <= req_address;
      wdata_q <= req_wdata;
    end
  end

  // Request decode and error classification from the latched request.
  always_comb begin
    dec          = decode_op(op_q);
    idx          = addr_q[ADDR_BITS+1:2];
    out_of_range = (addr_q >> (ADDR_BITS + 2)) != 32'd0;
    err          = !dec.legal || out_of_range || misaligned(dec.size, addr_q[1:0]);
    rword        = mem[idx];
  end

  mem_lane_align u_align (
    .size      (dec.size),
    .byte_off  (addr_q[1:0]),
    .sign_ext  (dec.sign_ext),
    .wdata     (wdata_q),
    .rword     (rword),
    .byte_en   (byte_en),
    .wword     (wword),
    .load_data (load_data)
  );

  assign wr_en = enter_resp && dec.is_store && !err && !reset;

  always_ff @(posedge clock) begin
    if (wr_en) mem[idx] <= wword;
  end

  // Response register: loaded on the edge that enters RESPOND, held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= enter_resp;
      if (enter_resp) begin
        resp_error <= err;
        resp_rdata <= (dec.is_load && !err) ? load_data : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed loads/stores, error
// cases, back-to-back handshake and reset during a pending store.
module tb_data_memory_responder;
  import mips_mem_pkg::*;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = 6'd0;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   resp_cnt = 0;
  int   issued = 0;
  int   last_acc = 0;
  int   prev_acc = 0;

  data_memory_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      check("ready_low_in_respond", {31'd0, req_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_response: got rdata %h error %b expected no response",
                 resp_rdata, resp_error);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_error"}, {31'd0, resp_error}, {31'd0, e.err});
        check({e.name, "_latency"}, cyc - e.acc, LAT);
      end
    end
  end

  task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input bit expect_resp, input bit hold);
    int   n;
    exp_t e;
    @(negedge clock);
    req_valid   = 1'b1;
    req_opcode  = op;
    req_address = a;
    req_wdata   = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL %s_accept: got req_ready %b expected 1 within 20 cycles", name, req_ready);
      req_valid = 1'b0;
    end else begin
      last_acc = cyc + 1;
      if (expect_resp) begin
        e.rdata = er;
        e.err   = ee;
        e.acc   = last_acc;
        e.name  = name;
        sb_q.push_back(e);
        issued++;
      end
      @(posedge clock);
      #1;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending responses expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("reset_ready", {31'd0, req_ready}, 32'd0);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_error", {31'd0, resp_error}, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Word, byte and halfword stores with readback through every load flavour.
    issue("sw_00",  OP_SW,  32'h00, 32'h11223344, 32'h0, 1'b0, 1, 0);
    issue("sw_10",  OP_SW,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0);
    issue("lw_10a", OP_LW,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0);
    issue("sb_11",  OP_SB,  32'h11, 32'h000000AA, 32'h0, 1'b0, 1, 0);
    issue("lw_10b", OP_LW,  32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 1, 0);
    issue("lb_11",  OP_LB,  32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 1, 0);
    issue("lbu_11", OP_LBU, 32'h11, 32'h0, 32'h000000AA, 1'b0, 1, 0);
    issue("sh_12",  OP_SH,  32'h12, 32'h00008001, 32'h0, 1'b0, 1, 0);
    issue("lh_12",  OP_LH,  32'h12, 32'h0, 32'hFFFF8001, 1'b0, 1, 0);
    issue("lhu_12", OP_LHU, 32'h12, 32'h0, 32'h00008001, 1'b0, 1, 0);
    issue("lw_10c", OP_LW,  32'h10, 32'h0, 32'hDEAA8001, 1'b0, 1, 0);
    issue("lb_13",  OP_LB,  32'h13, 32'h0, 32'h00000001, 1'b0, 1, 0);
    issue("lb_10",  OP_LB,  32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 1, 0);
    issue("lh_10",  OP_LH,  32'h10, 32'h0, 32'hFFFFDEAA, 1'b0, 1, 0);

    // Error responses: no data, no write.
    issue("lw_13_mis",  OP_LW,    32'h13,  32'h0, 32'h0, 1'b1, 1, 0);
    issue("lh_11_mis",  OP_LH,    32'h11,  32'h0, 32'h0, 1'b1, 1, 0);
    issue("sw_400_oor", OP_SW,    32'h400, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
    issue("bad_op",     6'b000000, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
    issue("lw_10d",     OP_LW,    32'h10,  32'h0, 32'hDEAA8001, 1'b0, 1, 0);
    issue("lw_00",      OP_LW,    32'h00,  32'h0, 32'h11223344, 1'b0, 1, 0);
    drain();

    // Continuous req_valid: each accept is LATENCY edges to the response,
    // one RESPOND cycle and one IDLE cycle after the previous accept.
    issue("hs_lw_10",  OP_LW,  32'h10, 32'h0, 32'hDEAA8001, 1'b0, 1, 1);
    prev_acc = last_acc;
    @(negedge clock);
    check("ready_low_in_wait", {31'd0, req_ready}, 32'd0);
    issue("hs_lhu_10", OP_LHU, 32'h10, 32'h0, 32'h0000DEAA, 1'b0, 1, 1);
    check("accept_spacing_1", last_acc - prev_acc, LAT + 2);
    prev_acc = last_acc;
    issue("hs_lw_00",  OP_LW,  32'h00, 32'h0, 32'h11223344, 1'b0, 1, 0);
    check("accept_spacing_2", last_acc - prev_acc, LAT + 2);
    drain();

    // Reset while a store is waiting drops it without a response.
    issue("sw_20_zero", OP_SW, 32'h20, 32'h00000000, 32'h0, 1'b0, 1, 0);
    drain();
    issue("sw_20_drop", OP_SW, 32'h20, 32'h12345678, 32'h0, 1'b0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_during_reset", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_midop_reset", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check("no_resp_after_reset", {31'd0, resp_valid}, 32'd0);
    end
    issue("lw_20",      OP_LW, 32'h20, 32'h0, 32'h00000000, 1'b0, 1, 0);
    issue("sh_21_mis",  OP_SH, 32'h21, 32'h0000FFFF, 32'h0, 1'b1, 1, 0);
    issue("lw_20b",     OP_LW, 32'h20, 32'h0, 32'h00000000, 1'b0, 1, 0);
    drain();

    repeat (3) @(negedge clock);
    check("response_count", resp_cnt, issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
